// File: rtl/axi4_arb2.sv
// axi4_arb2: 2:1 AXI4 arbiter sharing one master port between two sources.
// Read (AR) and write (AW+W) are arbitrated independently; B/R responses are
// steered back by ID bit 3, which carries the source index on the way out.
// Outstanding bursts per direction are capped at MAX_OUTSTANDING (1..15).
// Build option: define AXI4_ARB_FIXED_PRIO_EN to make inport0 win every
// contended grant instead of round-robin.
`timescale 1ns/1ps
module axi4_arb2 #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // inport0
  input  logic        inport0_awvalid_i,
  input  logic [31:0] inport0_awaddr_i,
  input  logic [3:0]  inport0_awid_i,
  input  logic [7:0]  inport0_awlen_i,
  input  logic [1:0]  inport0_awburst_i,
  output logic        inport0_awready_o,
  input  logic        inport0_wvalid_i,
  input  logic [31:0] inport0_wdata_i,
  input  logic [3:0]  inport0_wstrb_i,
  input  logic        inport0_wlast_i,
  output logic        inport0_wready_o,
  output logic        inport0_bvalid_o,
  output logic [1:0]  inport0_bresp_o,
  output logic [3:0]  inport0_bid_o,
  input  logic        inport0_bready_i,
  input  logic        inport0_arvalid_i,
  input  logic [31:0] inport0_araddr_i,
  input  logic [3:0]  inport0_arid_i,
  input  logic [7:0]  inport0_arlen_i,
  input  logic [1:0]  inport0_arburst_i,
  output logic        inport0_arready_o,
  output logic        inport0_rvalid_o,
  output logic [31:0] inport0_rdata_o,
  output logic [1:0]  inport0_rresp_o,
  output logic [3:0]  inport0_rid_o,
  output logic        inport0_rlast_o,
  input  logic        inport0_rready_i,
  // inport1
  input  logic        inport1_awvalid_i,
  input  logic [31:0] inport1_awaddr_i,
  input  logic [3:0]  inport1_awid_i,
  input  logic [7:0]  inport1_awlen_i,
  input  logic [1:0]  inport1_awburst_i,
  output logic        inport1_awready_o,
  input  logic        inport1_wvalid_i,
  input  logic [31:0] inport1_wdata_i,
  input  logic [3:0]  inport1_wstrb_i,
  input  logic        inport1_wlast_i,
  output logic        inport1_wready_o,
  output logic        inport1_bvalid_o,
  output logic [1:0]  inport1_bresp_o,
  output logic [3:0]  inport1_bid_o,
  input  logic        inport1_bready_i,
  input  logic        inport1_arvalid_i,
  input  logic [31:0] inport1_araddr_i,
  input  logic [3:0]  inport1_arid_i,
  input  logic [7:0]  inport1_arlen_i,
  input  logic [1:0]  inport1_arburst_i,
  output logic        inport1_arready_o,
  output logic        inport1_rvalid_o,
  output logic [31:0] inport1_rdata_o,
  output logic [1:0]  inport1_rresp_o,
  output logic [3:0]  inport1_rid_o,
  output logic        inport1_rlast_o,
  input  logic        inport1_rready_i,
  // outport (master side)
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  input  logic        outport_awready_i,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  input  logic        outport_wready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  output logic        outport_bready_o,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_arready_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_rready_o
);

`ifdef AXI4_ARB_FIXED_PRIO_EN
  localparam bit RR_EN = 1'b0;
`else
  localparam bit RR_EN = 1'b1;
`endif
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  typedef enum logic {R_IDLE, R_BUSY} rd_state_e;
  typedef enum logic {W_IDLE, W_BUSY} wr_state_e;

  // Source-indexed views of both inports so the muxes below stay compact.
  logic [1:0]       awvalid, wvalid, wlast, arvalid, bready, rready;
  logic [1:0][31:0] awaddr, wdata, araddr;
  logic [1:0][3:0]  awid, arid, wstrb;
  logic [1:0][7:0]  awlen, arlen;
  logic [1:0][1:0]  awburst, arburst;
  logic [1:0]       awready, wready, arready, bvalid, rvalid;

  assign awvalid = {inport1_awvalid_i, inport0_awvalid_i};
  assign awaddr  = {inport1_awaddr_i,  inport0_awaddr_i};
  assign awid    = {inport1_awid_i,    inport0_awid_i};
  assign awlen   = {inport1_awlen_i,   inport0_awlen_i};
  assign awburst = {inport1_awburst_i, inport0_awburst_i};
  assign wvalid  = {inport1_wvalid_i,  inport0_wvalid_i};
  assign wdata   = {inport1_wdata_i,   inport0_wdata_i};
  assign wstrb   = {inport1_wstrb_i,   inport0_wstrb_i};
  assign wlast   = {inport1_wlast_i,   inport0_wlast_i};
  assign bready  = {inport1_bready_i,  inport0_bready_i};
  assign arvalid = {inport1_arvalid_i, inport0_arvalid_i};
  assign araddr  = {inport1_araddr_i,  inport0_araddr_i};
  assign arid    = {inport1_arid_i,    inport0_arid_i};
  assign arlen   = {inport1_arlen_i,   inport0_arlen_i};
  assign arburst = {inport1_arburst_i, inport0_arburst_i};
  assign rready  = {inport1_rready_i,  inport0_rready_i};

  // Inbound id[3] is overwritten with the source index, so it is never read.
  logic unused_id_msb;
  assign unused_id_msb = ^{awid[0][3], awid[1][3], arid[0][3], arid[1][3]};

  // Winner among requesters: the other port on contention (round-robin) or
  // always port 0 (fixed priority); a lone requester wins directly.
  function automatic logic pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) pick = RR_EN ? ~last : 1'b0;
    else              pick = req[1];
  endfunction

  rd_state_e  rd_state_q;
  logic       rd_gnt_q, rd_last_q;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  wr_state_e  wr_state_q;
  logic       wr_gnt_q, wr_last_q, aw_done_q, w_done_q;
  logic [3:0] wr_cnt_q, wr_cnt_d;

  logic rd_busy, wr_busy, ar_hs, aw_hs, wlast_hs, r_done, b_done;
  logic rsel, bsel;

  assign rd_busy = (rd_state_q == R_BUSY);
  assign wr_busy = (wr_state_q == W_BUSY);

  // Master-side request channels are driven only from the latched grant.
  assign outport_arvalid_o = rd_busy & arvalid[rd_gnt_q];
  assign outport_araddr_o  = araddr[rd_gnt_q];
  assign outport_arid_o    = {rd_gnt_q, arid[rd_gnt_q][2:0]};
  assign outport_arlen_o   = arlen[rd_gnt_q];
  assign outport_arburst_o = arburst[rd_gnt_q];

  assign outport_awvalid_o = wr_busy & awvalid[wr_gnt_q] & ~aw_done_q;
  assign outport_awaddr_o  = awaddr[wr_gnt_q];
  assign outport_awid_o    = {wr_gnt_q, awid[wr_gnt_q][2:0]};
  assign outport_awlen_o   = awlen[wr_gnt_q];
  assign outport_awburst_o = awburst[wr_gnt_q];

  assign outport_wvalid_o  = wr_busy & wvalid[wr_gnt_q] & ~w_done_q;
  assign outport_wdata_o   = wdata[wr_gnt_q];
  assign outport_wstrb_o   = wstrb[wr_gnt_q];
  assign outport_wlast_o   = wlast[wr_gnt_q];

  assign ar_hs    = outport_arvalid_o & outport_arready_i;
  assign aw_hs    = outport_awvalid_o & outport_awready_i;
  assign wlast_hs = outport_wvalid_o & outport_wready_i & outport_wlast_o;

  // Responses steer on id[3]; gated by reset so nothing leaks while held in reset.
  assign rsel = outport_rid_i[3];
  assign bsel = outport_bid_i[3];
  assign outport_rready_o = rst_ni & rready[rsel];
  assign outport_bready_o = rst_ni & bready[bsel];
  assign r_done = outport_rvalid_i & outport_rready_o & outport_rlast_i;
  assign b_done = outport_bvalid_i & outport_bready_o;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign arready[gi] = rd_busy & (rd_gnt_q == 1'(gi)) & outport_arready_i;
    assign awready[gi] = wr_busy & (wr_gnt_q == 1'(gi)) & ~aw_done_q & outport_awready_i;
    assign wready[gi]  = wr_busy & (wr_gnt_q == 1'(gi)) & ~w_done_q & outport_wready_i;
    assign rvalid[gi]  = rst_ni & outport_rvalid_i & (rsel == 1'(gi));
    assign bvalid[gi]  = rst_ni & outport_bvalid_i & (bsel == 1'(gi));
  end

  assign inport0_awready_o = awready[0];
  assign inport1_awready_o = awready[1];
  assign inport0_wready_o  = wready[0];
  assign inport1_wready_o  = wready[1];
  assign inport0_arready_o = arready[0];
  assign inport1_arready_o = arready[1];

  assign inport0_bvalid_o = bvalid[0];
  assign inport1_bvalid_o = bvalid[1];
  assign inport0_bresp_o  = outport_bresp_i;
  assign inport1_bresp_o  = outport_bresp_i;
  assign inport0_bid_o    = {1'b0, outport_bid_i[2:0]};
  assign inport1_bid_o    = {1'b0, outport_bid_i[2:0]};

  assign inport0_rvalid_o = rvalid[0];
  assign inport1_rvalid_o = rvalid[1];
  assign inport0_rdata_o  = outport_rdata_i;
  assign inport1_rdata_o  = outport_rdata_i;
  assign inport0_rresp_o  = outport_rresp_i;
  assign inport1_rresp_o  = outport_rresp_i;
  assign inport0_rid_o    = {1'b0, outport_rid_i[2:0]};
  assign inport1_rid_o    = {1'b0, outport_rid_i[2:0]};
  assign inport0_rlast_o  = outport_rlast_i;
  assign inport1_rlast_o  = outport_rlast_i;

  // Outstanding-burst counters: simultaneous inc and dec cancel out.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (ar_hs && !r_done)                        rd_cnt_d = rd_cnt_q + 4'd1;
    else if (!ar_hs && r_done && rd_cnt_q != 0)  rd_cnt_d = rd_cnt_q - 4'd1;
    if (aw_hs && !b_done)                        wr_cnt_d = wr_cnt_q + 4'd1;
    else if (!aw_hs && b_done && wr_cnt_q != 0)  wr_cnt_d = wr_cnt_q - 4'd1;
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Read FSM: latch a grant when below the cap, release after the AR handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_q <= R_IDLE;
      rd_gnt_q   <= 1'b0;
      rd_last_q  <= 1'b1;
    end else begin
      case (rd_state_q)
        R_IDLE: if (|arvalid && rd_cnt_q < MAX_CNT) begin
          rd_gnt_q   <= pick(arvalid, rd_last_q);
          rd_last_q  <= pick(arvalid, rd_last_q);
          rd_state_q <= R_BUSY;
        end
        R_BUSY: if (ar_hs) rd_state_q <= R_IDLE;
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // Write FSM: AW and the full W burst complete in either order; the grant is
  // held until both are done so bursts from the two sources never interleave.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= W_IDLE;
      wr_gnt_q   <= 1'b0;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: if (|awvalid && wr_cnt_q < MAX_CNT) begin
          wr_gnt_q   <= pick(awvalid, wr_last_q);
          wr_last_q  <= pick(awvalid, wr_last_q);
          aw_done_q  <= 1'b0;
          w_done_q   <= 1'b0;
          wr_state_q <= W_BUSY;
        end
        W_BUSY: begin
          if (aw_hs)    aw_done_q <= 1'b1;
          if (wlast_hs) w_done_q  <= 1'b1;
          if ((aw_done_q || aw_hs) && (w_done_q || wlast_hs)) wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_arb2.sv
// Directed bench for axi4_arb2 with scoreboards on the AR, AW and W channels.
`timescale 1ns/1ps
module tb_axi4_arb2;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        i0_awvalid, i1_awvalid, i0_wvalid, i1_wvalid, i0_wlast, i1_wlast;
  logic [31:0] i0_awaddr, i1_awaddr, i0_wdata, i1_wdata, i0_araddr, i1_araddr;
  logic [3:0]  i0_awid, i1_awid, i0_wstrb, i1_wstrb, i0_arid, i1_arid;
  logic [7:0]  i0_awlen, i1_awlen, i0_arlen, i1_arlen;
  logic [1:0]  i0_awburst, i1_awburst, i0_arburst, i1_arburst;
  logic        i0_bready, i1_bready, i0_arvalid, i1_arvalid, i0_rready, i1_rready;
  logic        i0_awready_o, i1_awready_o, i0_wready_o, i1_wready_o, i0_arready_o, i1_arready_o;
  logic        i0_bvalid_o, i1_bvalid_o, i0_rvalid_o, i1_rvalid_o, i0_rlast_o, i1_rlast_o;
  logic [1:0]  i0_bresp_o, i1_bresp_o, i0_rresp_o, i1_rresp_o;
  logic [3:0]  i0_bid_o, i1_bid_o, i0_rid_o, i1_rid_o;
  logic [31:0] i0_rdata_o, i1_rdata_o;

  logic        outport_awvalid_o, outport_wvalid_o, outport_wlast_o, outport_bready_o;
  logic        outport_arvalid_o, outport_rready_o;
  logic [31:0] outport_awaddr_o, outport_wdata_o, outport_araddr_o;
  logic [3:0]  outport_awid_o, outport_wstrb_o, outport_arid_o;
  logic [7:0]  outport_awlen_o, outport_arlen_o;
  logic [1:0]  outport_awburst_o, outport_arburst_o;
  logic        outport_awready_i, outport_wready_i, outport_bvalid_i, outport_arready_i;
  logic        outport_rvalid_i, outport_rlast_i;
  logic [1:0]  outport_bresp_i, outport_rresp_i;
  logic [3:0]  outport_bid_i, outport_rid_i;
  logic [31:0] outport_rdata_i;

  axi4_arb2 #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .inport0_awvalid_i(i0_awvalid), .inport0_awaddr_i(i0_awaddr), .inport0_awid_i(i0_awid),
    .inport0_awlen_i(i0_awlen), .inport0_awburst_i(i0_awburst), .inport0_awready_o(i0_awready_o),
    .inport0_wvalid_i(i0_wvalid), .inport0_wdata_i(i0_wdata), .inport0_wstrb_i(i0_wstrb),
    .inport0_wlast_i(i0_wlast), .inport0_wready_o(i0_wready_o),
    .inport0_bvalid_o(i0_bvalid_o), .inport0_bresp_o(i0_bresp_o), .inport0_bid_o(i0_bid_o),
    .inport0_bready_i(i0_bready),
    .inport0_arvalid_i(i0_arvalid), .inport0_araddr_i(i0_araddr), .inport0_arid_i(i0_arid),
    .inport0_arlen_i(i0_arlen), .inport0_arburst_i(i0_arburst), .inport0_arready_o(i0_arready_o),
    .inport0_rvalid_o(i0_rvalid_o), .inport0_rdata_o(i0_rdata_o), .inport0_rresp_o(i0_rresp_o),
    .inport0_rid_o(i0_rid_o), .inport0_rlast_o(i0_rlast_o), .inport0_rready_i(i0_rready),
    .inport1_awvalid_i(i1_awvalid), .inport1_awaddr_i(i1_awaddr), .inport1_awid_i(i1_awid),
    .inport1_awlen_i(i1_awlen), .inport1_awburst_i(i1_awburst), .inport1_awready_o(i1_awready_o),
    .inport1_wvalid_i(i1_wvalid), .inport1_wdata_i(i1_wdata), .inport1_wstrb_i(i1_wstrb),
    .inport1_wlast_i(i1_wlast), .inport1_wready_o(i1_wready_o),
    .inport1_bvalid_o(i1_bvalid_o), .inport1_bresp_o(i1_bresp_o), .inport1_bid_o(i1_bid_o),
    .inport1_bready_i(i1_bready),
    .inport1_arvalid_i(i1_arvalid), .inport1_araddr_i(i1_araddr), .inport1_arid_i(i1_arid),
    .inport1_arlen_i(i1_arlen), .inport1_arburst_i(i1_arburst), .inport1_arready_o(i1_arready_o),
    .inport1_rvalid_o(i1_rvalid_o), .inport1_rdata_o(i1_rdata_o), .inport1_rresp_o(i1_rresp_o),
    .inport1_rid_o(i1_rid_o), .inport1_rlast_o(i1_rlast_o), .inport1_rready_i(i1_rready),
    .outport_awvalid_o(outport_awvalid_o), .outport_awaddr_o(outport_awaddr_o),
    .outport_awid_o(outport_awid_o), .outport_awlen_o(outport_awlen_o),
    .outport_awburst_o(outport_awburst_o), .outport_awready_i(outport_awready_i),
    .outport_wvalid_o(outport_wvalid_o), .outport_wdata_o(outport_wdata_o),
    .outport_wstrb_o(outport_wstrb_o), .outport_wlast_o(outport_wlast_o),
    .outport_wready_i(outport_wready_i),
    .outport_bvalid_i(outport_bvalid_i), .outport_bresp_i(outport_bresp_i),
    .outport_bid_i(outport_bid_i), .outport_bready_o(outport_bready_o),
    .outport_arvalid_o(outport_arvalid_o), .outport_araddr_o(outport_araddr_o),
    .outport_arid_o(outport_arid_o), .outport_arlen_o(outport_arlen_o),
    .outport_arburst_o(outport_arburst_o), .outport_arready_i(outport_arready_i),
    .outport_rvalid_i(outport_rvalid_i), .outport_rdata_i(outport_rdata_i),
    .outport_rresp_i(outport_rresp_i), .outport_rid_i(outport_rid_i),
    .outport_rlast_i(outport_rlast_i), .outport_rready_o(outport_rready_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Expected master-side transfers: {addr,id,len,burst} and {data,strb,last}.
  logic [45:0] ar_q[$];
  logic [45:0] aw_q[$];
  logic [36:0] w_q[$];

  logic [14:0] ctl_vec;
  assign ctl_vec = {outport_awvalid_o, outport_wvalid_o, outport_arvalid_o, outport_bready_o,
                    outport_rready_o, i0_awready_o, i0_wready_o, i0_arready_o, i0_bvalid_o,
                    i0_rvalid_o, i1_awready_o, i1_wready_o, i1_arready_o, i1_bvalid_o, i1_rvalid_o};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {i0_awvalid, i1_awvalid, i0_wvalid, i1_wvalid, i0_wlast, i1_wlast} = '0;
    {i0_awaddr, i1_awaddr, i0_wdata, i1_wdata, i0_araddr, i1_araddr} = '0;
    {i0_awid, i1_awid, i0_wstrb, i1_wstrb, i0_arid, i1_arid} = '0;
    {i0_awlen, i1_awlen, i0_arlen, i1_arlen, i0_awburst, i1_awburst, i0_arburst, i1_arburst} = '0;
    {i0_bready, i1_bready, i0_arvalid, i1_arvalid, i0_rready, i1_rready} = '0;
    {outport_awready_i, outport_wready_i, outport_bvalid_i, outport_arready_i} = '0;
    {outport_rvalid_i, outport_rlast_i, outport_bresp_i, outport_rresp_i} = '0;
    {outport_bid_i, outport_rid_i, outport_rdata_i} = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    step(2);
    check("rst_ctl_zero", ctl_vec, 15'h0);
    check("rst_counters", {dut.rd_cnt_q, dut.wr_cnt_q}, 8'h00);
    ar_q.delete(); aw_q.delete(); w_q.delete();
    rst_ni = 1'b1;
  endtask

  // Waits (bounded) for an AR handshake to be pending, then steps over it.
  task automatic wait_ar_hs(input string tag);
    int c;
    c = 0;
    while (!(outport_arvalid_o && outport_arready_i) && c < 20) begin
      step(1);
      c++;
    end
    check(tag, (c < 20), 1'b1);
    step(1);
  endtask

  task automatic drive_i1_beat(input int b);
    i1_wvalid = 1'b1;
    i1_wdata  = 32'hB000_0000 + 32'(b);
    i1_wstrb  = 4'hF;
    i1_wlast  = (b == 7);
  endtask

  // Scoreboard side: compare each master-side handshake with the oldest expectation.
  always @(negedge clk) begin
    logic [45:0] ea;
    logic [36:0] ew;
    if (outport_arvalid_o && outport_arready_i) begin
      n_checks++;
      assert (ar_q.size() > 0) else begin
        n_fail++;
        $error("FAIL ar_unexpected: observed %0h expected none", outport_araddr_o);
      end
      if (ar_q.size() > 0) begin
        ea = ar_q.pop_front();
        check("ar_xfer", {outport_araddr_o, outport_arid_o, outport_arlen_o, outport_arburst_o}, ea);
      end
    end
    if (outport_awvalid_o && outport_awready_i) begin
      n_checks++;
      assert (aw_q.size() > 0) else begin
        n_fail++;
        $error("FAIL aw_unexpected: observed %0h expected none", outport_awaddr_o);
      end
      if (aw_q.size() > 0) begin
        ea = aw_q.pop_front();
        check("aw_xfer", {outport_awaddr_o, outport_awid_o, outport_awlen_o, outport_awburst_o}, ea);
      end
    end
    if (outport_wvalid_o && outport_wready_i) begin
      n_checks++;
      assert (w_q.size() > 0) else begin
        n_fail++;
        $error("FAIL w_unexpected: observed %0h expected none", outport_wdata_o);
      end
      if (w_q.size() > 0) begin
        ew = w_q.pop_front();
        check("w_beat", {outport_wdata_o, outport_wstrb_o, outport_wlast_o}, ew);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beat, c;
    logic hs;
    logic p;

    // ---- 1: single AR from inport0, 4 R beats routed back ----
    do_reset();
    i0_arvalid = 1'b1; i0_araddr = 32'h1000; i0_arid = 4'h2; i0_arlen = 8'd3; i0_arburst = 2'b01;
    outport_arready_i = 1'b1;
    ar_q.push_back({32'h1000, 4'h2, 8'd3, 2'b01});
    #1;
    check("t1_ar_not_yet", outport_arvalid_o, 1'b0);
    step(1);
    check("t1_arvalid", outport_arvalid_o, 1'b1);
    check("t1_arid", outport_arid_o, 4'h2);
    check("t1_arready", {i1_arready_o, i0_arready_o}, 2'b01);
    step(1);
    i0_arvalid = 1'b0;
    check("t1_rd_cnt1", dut.rd_cnt_q, 4'd1);
    i0_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      outport_rvalid_i = 1'b1; outport_rid_i = 4'h2; outport_rdata_i = 32'hD00 + 32'(k);
      outport_rlast_i = (k == 3);
      #1;
      check("t1_rvalid_route", {i1_rvalid_o, i0_rvalid_o}, 2'b01);
      check("t1_rdata", {i0_rid_o, i0_rdata_o, i0_rlast_o}, {4'h2, 32'hD00 + 32'(k), (k == 3)});
      check("t1_rready", outport_rready_o, 1'b1);
      step(1);
    end
    outport_rvalid_i = 1'b0;
    check("t1_rd_cnt0", dut.rd_cnt_q, 4'd0);

    // ---- 2: contended AR, round-robin starting with inport0 ----
    do_reset();
    i0_arvalid = 1'b1; i0_araddr = 32'h2000; i0_arid = 4'h9; i0_arlen = 8'd0; i0_arburst = 2'b01;
    i1_arvalid = 1'b1; i1_araddr = 32'h2100; i1_arid = 4'h3; i1_arlen = 8'd1; i1_arburst = 2'b10;
    i0_rready = 1'b1; i1_rready = 1'b1; outport_arready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) ar_q.push_back({32'h2000, 4'h1, 8'd0, 2'b01});
      else            ar_q.push_back({32'h2100, 4'hB, 8'd1, 2'b10});
    end
    for (int k = 0; k < 4; k++) begin
      p = 1'(k % 2);
      wait_ar_hs("t2_ar_wait");
      if (k == 3) begin i0_arvalid = 1'b0; i1_arvalid = 1'b0; end
      outport_rvalid_i = 1'b1; outport_rlast_i = 1'b1; outport_rdata_i = 32'(k);
      outport_rid_i = p ? 4'hB : 4'h1;
      #1;
      check("t2_r_route", {i1_rvalid_o, i0_rvalid_o}, p ? 2'b10 : 2'b01);
      check("t2_r_id", p ? i1_rid_o : i0_rid_o, p ? 4'h3 : 4'h1);
      step(1);
      outport_rvalid_i = 1'b0;
    end
    check("t2_ar_q_empty", ar_q.size(), 0);

    // ---- 3: inport1 8-beat write with W ahead of AW; inport0 waits ----
    do_reset();
    i1_awvalid = 1'b1; i1_awaddr = 32'h3000; i1_awid = 4'h4; i1_awlen = 8'd7; i1_awburst = 2'b01;
    outport_awready_i = 1'b0; outport_wready_i = 1'b1;
    aw_q.push_back({32'h3000, 4'hC, 8'd7, 2'b01});
    for (int b = 0; b < 8; b++) w_q.push_back({32'hB000_0000 + 32'(b), 4'hF, (b == 7)});
    beat = 0;
    drive_i1_beat(0);
    step(1);
    i0_awvalid = 1'b1; i0_awaddr = 32'h4000; i0_awid = 4'hD; i0_awlen = 8'd0; i0_awburst = 2'b01;
    i0_wvalid = 1'b1; i0_wdata = 32'hA0A0_0000; i0_wstrb = 4'h3; i0_wlast = 1'b1;
    aw_q.push_back({32'h4000, 4'h5, 8'd0, 2'b01});
    w_q.push_back({32'hA0A0_0000, 4'h3, 1'b1});
    c = 0;
    while (beat < 8 && c < 40) begin
      check("t3_i0_blocked", {i0_awready_o, i0_wready_o}, 2'b00);
      check("t3_aw_pending", outport_awvalid_o, 1'b1);
      hs = i1_wvalid && i1_wready_o;
      step(1);
      c++;
      if (hs) begin
        beat++;
        if (beat < 8) drive_i1_beat(beat);
        else          i1_wvalid = 1'b0;
      end
    end
    check("t3_w_beats", beat, 8);
    check("t3_w_held_after_last", outport_wvalid_o, 1'b0);
    outport_awready_i = 1'b1;
    step(1);
    i1_awvalid = 1'b0;
    step(2);
    i0_awvalid = 1'b0; i0_wvalid = 1'b0;
    check("t3_wr_cnt2", dut.wr_cnt_q, 4'd2);
    check("t3_queues_empty", {16'(aw_q.size()), 16'(w_q.size())}, 32'h0);
    outport_bvalid_i = 1'b1; outport_bid_i = 4'hC; outport_bresp_i = 2'b00; i1_bready = 1'b1;
    #1;
    check("t3_b1_route", {i1_bvalid_o, i0_bvalid_o, i1_bid_o}, {2'b10, 4'h4});
    check("t3_b1_ready", outport_bready_o, 1'b1);
    step(1);
    outport_bid_i = 4'h5; outport_bresp_i = 2'b10; i0_bready = 1'b1; i1_bready = 1'b0;
    #1;
    check("t3_b0_route", {i1_bvalid_o, i0_bvalid_o, i0_bid_o, i0_bresp_o}, {2'b01, 4'h5, 2'b10});
    step(1);
    outport_bvalid_i = 1'b0;
    check("t3_wr_cnt0", dut.wr_cnt_q, 4'd0);

    // ---- 4: outstanding cap (2) with B withheld ----
    do_reset();
    i0_awvalid = 1'b1; i0_awaddr = 32'h5000; i0_awid = 4'h6; i0_awlen = 8'd0; i0_awburst = 2'b01;
    i0_wvalid = 1'b1; i0_wdata = 32'hC0DE_0000; i0_wstrb = 4'hF; i0_wlast = 1'b1;
    outport_awready_i = 1'b1; outport_wready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      aw_q.push_back({32'h5000, 4'h6, 8'd0, 2'b01});
      w_q.push_back({32'hC0DE_0000, 4'hF, 1'b1});
    end
    step(4);
    check("t4_wr_cnt_max", dut.wr_cnt_q, 4'(MAXO));
    for (int k = 0; k < 3; k++) begin
      check("t4_blocked", {outport_awvalid_o, i0_awready_o}, 2'b00);
      step(1);
    end
    outport_bvalid_i = 1'b1; outport_bid_i = 4'h6; i0_bready = 1'b1;
    step(1);
    outport_bvalid_i = 1'b0;
    check("t4_no_grant_yet", outport_awvalid_o, 1'b0);
    step(1);
    check("t4_grant_after_b", outport_awvalid_o, 1'b1);
    step(1);
    i0_awvalid = 1'b0; i0_wvalid = 1'b0;
    check("t4_wr_cnt_max2", dut.wr_cnt_q, 4'(MAXO));
    outport_bvalid_i = 1'b1;
    step(2);
    outport_bvalid_i = 1'b0;
    check("t4_wr_cnt0", dut.wr_cnt_q, 4'd0);
    check("t4_queues_empty", {16'(aw_q.size()), 16'(w_q.size())}, 32'h0);

    // ---- 6: reset asserted during beat 3 of an 8-beat write ----
    do_reset();
    i1_awvalid = 1'b1; i1_awaddr = 32'h6000; i1_awid = 4'h1; i1_awlen = 8'd7; i1_awburst = 2'b01;
    outport_awready_i = 1'b1; outport_wready_i = 1'b1; i1_bready = 1'b1; i1_rready = 1'b1;
    aw_q.push_back({32'h6000, 4'h9, 8'd7, 2'b01});
    for (int b = 0; b < 8; b++) w_q.push_back({32'hB000_0000 + 32'(b), 4'hF, (b == 7)});
    drive_i1_beat(0);
    step(2);
    drive_i1_beat(1);
    step(1);
    drive_i1_beat(2);
    step(1);
    check("t6_wr_cnt_pre", dut.wr_cnt_q, 4'd1);
    drive_i1_beat(3);
    check("t6_wvalid_pre", outport_wvalid_o, 1'b1);
    #1;
    rst_ni = 1'b0;
    #1;
    check("t6_ctl_zero", ctl_vec, 15'h0);
    check("t6_fsm_idle", {1'(dut.rd_state_q), 1'(dut.wr_state_q)}, 2'b00);
    check("t6_counters", {dut.rd_cnt_q, dut.wr_cnt_q}, 8'h00);
    check("t6_w_consumed", w_q.size(), 5);
    w_q.delete();
    do_reset();

    check("end_queues_empty", {16'(ar_q.size()), 16'(aw_q.size()), 16'(w_q.size())}, 48'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
